// File: rtl/cpu_pkg.sv
// Shared CPU types: register-file word/index types and the writeback queue entry.
package cpu_pkg;
  localparam int WORD_W  = 32;
  localparam int RADDR_W = 5;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [RADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t rd;
    word_t     data;
  } wb_entry_t;

  localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/writeback_fifo.sv
// In-order FIFO of writeback entries; per-slot valid bits let the parent see every queued rd.
module writeback_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  wb_entry_t             i_entry,
  input  logic                  i_pop,
  output wb_entry_t             o_head,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH-1:0]      o_vld,
  output wb_entry_t [DEPTH-1:0] o_entries
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]           r_wptr, r_rptr;
  logic [DEPTH-1:0]      r_vld;
  wb_entry_t [DEPTH-1:0] r_mem;
  logic                  w_push, w_pop;

  // Extra MSB on each pointer separates full (MSBs differ) from empty (equal).
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_vld  <= '0;
    end else begin
      if (w_push) begin
        r_wptr                <= r_wptr + (AW+1)'(1);
        r_vld[r_wptr[AW-1:0]] <= 1'b1;
      end
      if (w_pop) begin
        r_rptr                <= r_rptr + (AW+1)'(1);
        r_vld[r_rptr[AW-1:0]] <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_entry;
  end

  assign o_head    = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign o_vld     = r_vld;
  assign o_entries = r_mem;
endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: arbitrates ALU/load results into an in-order queue, drives the
// register-file write port and exports the set of pending destinations.
module writeback_unit
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH     = WORD_W,
  parameter int REG_ADDR_WIDTH = RADDR_W,
  parameter int QUEUE_DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [REG_ADDR_WIDTH-1:0]    alu_rd,
  input  logic [DATA_WIDTH-1:0]        alu_data,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [REG_ADDR_WIDTH-1:0]    mem_rd,
  input  logic [DATA_WIDTH-1:0]        mem_data,
  output logic [REG_ADDR_WIDTH-1:0]    write_register,
  output logic [DATA_WIDTH-1:0]        write_data,
  output logic                         write_activate,
  input  logic                         write_done,
  output logic [2**REG_ADDR_WIDTH-1:0] pending_mask,
  output logic [31:0]                  retired_count
);
  localparam int NREGS = 2**REG_ADDR_WIDTH;

  logic                        w_full, w_empty;
  logic                        w_mem_go, w_alu_go, w_push, w_pop;
  wb_entry_t                   w_in, w_head;
  logic [QUEUE_DEPTH-1:0]      w_vld;
  wb_entry_t [QUEUE_DEPTH-1:0] w_entries;
  logic [NREGS-1:0]            w_pending;
  logic [31:0]                 r_retired;

  // Loads win over the ALU; neither is accepted once the queue is full.
  assign mem_ready = !w_full;
  assign alu_ready = !w_full && !mem_valid;
  assign w_mem_go  = mem_valid && mem_ready;
  assign w_alu_go  = alu_valid && alu_ready;

  always_comb begin
    w_in = '0;
    if (w_mem_go) begin
      w_in.rd   = mem_rd;
      w_in.data = mem_data;
    end else begin
      w_in.rd   = alu_rd;
      w_in.data = alu_data;
    end
  end

  // x0 results complete the handshake but are dropped before reaching the queue.
  assign w_push = (w_mem_go || w_alu_go) && (w_in.rd != ZERO_REG);
  assign w_pop  = write_done && !w_empty;

  writeback_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .i_push    (w_push),
    .i_entry   (w_in),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_vld     (w_vld),
    .o_entries (w_entries)
  );

  assign write_activate = !w_empty;
  assign write_register = w_head.rd;
  assign write_data     = w_head.data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_retired <= '0;
    else if (w_pop) r_retired <= r_retired + 32'd1;
  end
  assign retired_count = r_retired;

  always_comb begin
    w_pending = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++)
      if (w_vld[i]) w_pending[w_entries[i].rd] = 1'b1;
    w_pending[0] = 1'b0;
  end
  assign pending_mask = w_pending;
endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: accepted results are queued as expected
// commits and checked against the write port every cycle.
module tb_writeback_unit;
  import cpu_pkg::*;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [4:0]  alu_rd, mem_rd, write_register;
  logic [31:0] alu_data, mem_data, write_data;
  logic        write_activate, write_done;
  logic [31:0] pending_mask, retired_count;

  int checks   = 0;
  int failures = 0;
  wb_entry_t   exp_q[$];
  logic [31:0] model_ret = '0;

  always #5 clk = ~clk;

  writeback_unit #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .QUEUE_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_rd         (mem_rd),
    .mem_data       (mem_data),
    .write_register (write_register),
    .write_data     (write_data),
    .write_activate (write_activate),
    .write_done     (write_done),
    .pending_mask   (pending_mask),
    .retired_count  (retired_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle model check, then predict what the coming edge commits and accepts.
  always @(negedge clk) begin
    if (rst) begin
      int n;
      logic [31:0] m;
      wb_entry_t e;
      n = exp_q.size();
      chk("sb_wa", write_activate, n != 0);
      chk("sb_mem_ready", mem_ready, n < DEPTH);
      chk("sb_alu_ready", alu_ready, (n < DEPTH) && !mem_valid);
      chk("sb_retired", retired_count, model_ret);
      m = '0;
      foreach (exp_q[i]) m[exp_q[i].rd] = 1'b1;
      m[0] = 1'b0;
      chk("sb_pmask", pending_mask, m);
      if (n != 0) begin
        chk("sb_head_rd", write_register, exp_q[0].rd);
        chk("sb_head_data", write_data, exp_q[0].data);
      end else begin
        chk("sb_idle_rd", write_register, 0);
        chk("sb_idle_data", write_data, 0);
      end
      if (n != 0 && write_done) begin
        void'(exp_q.pop_front());
        model_ret = model_ret + 32'd1;
      end
      if (n < DEPTH) begin
        if (mem_valid) begin
          e.rd = mem_rd; e.data = mem_data;
          if (mem_rd != 5'd0) exp_q.push_back(e);
        end else if (alu_valid) begin
          e.rd = alu_rd; e.data = alu_data;
          if (alu_rd != 5'd0) exp_q.push_back(e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    mem_valid = 0; mem_rd = '0; mem_data = '0;
    write_done = 0;
    #1;
    chk("rst_wa", write_activate, 0);
    chk("rst_pmask", pending_mask, 0);
    chk("rst_retired", retired_count, 0);
    #10 rst = 1'b1;
    step();
    chk("idle_alu_ready", alu_ready, 1);
    chk("idle_mem_ready", mem_ready, 1);

    // single ALU result, committed on the following edge
    alu_valid = 1; alu_rd = 5'd1; alu_data = 32'hDEAD_BEEF; write_done = 1;
    step();
    alu_valid = 0;
    chk("t2_wa", write_activate, 1);
    chk("t2_rd", write_register, 1);
    chk("t2_data", write_data, 32'hDEAD_BEEF);
    chk("t2_pmask", pending_mask, 32'h0000_0002);
    step();
    chk("t2_wa_after", write_activate, 0);
    chk("t2_pmask_after", pending_mask, 0);
    chk("t2_retired", retired_count, 1);

    // load beats ALU in the same cycle
    mem_valid = 1; mem_rd = 5'd3; mem_data = 32'h2222_2222;
    alu_valid = 1; alu_rd = 5'd2; alu_data = 32'h1111_1111;
    #1;
    chk("t3_alu_ready", alu_ready, 0);
    chk("t3_mem_ready", mem_ready, 1);
    step();
    mem_valid = 0;
    chk("t3_head_first", write_register, 3);
    step();
    alu_valid = 0;
    chk("t3_head_second", write_register, 2);
    chk("t3_retired1", retired_count, 2);
    step();
    chk("t3_retired2", retired_count, 3);
    chk("t3_wa", write_activate, 0);

    // x0 write is swallowed
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    #1;
    chk("t4_alu_ready", alu_ready, 1);
    step();
    alu_valid = 0;
    chk("t4_wa", write_activate, 0);
    chk("t4_pmask", pending_mask, 0);
    step();
    chk("t4_retired", retired_count, 3);

    // fill the queue while the register file stalls
    write_done = 0;
    for (int k = 4; k < 8; k++) begin
      mem_valid = 1; mem_rd = 5'(k); mem_data = 32'hA000_0000 | k;
      step();
    end
    mem_rd = 5'd8; mem_data = 32'hA000_0008;
    #1;
    chk("t5_mem_ready_full", mem_ready, 0);
    chk("t5_alu_ready_full", alu_ready, 0);
    chk("t5_pmask_full", pending_mask, 32'h0000_00F0);
    repeat (2) step();
    chk("t5_pmask_hold", pending_mask, 32'h0000_00F0);
    chk("t5_head_hold", write_register, 4);
    mem_valid = 0; write_done = 1;
    step();
    chk("t5_ready_back", mem_ready, 1);
    chk("t5_head_next", write_register, 5);
    repeat (3) step();
    chk("t5_retired", retired_count, 7);
    chk("t5_wa_drained", write_activate, 0);

    // random traffic against the scoreboard
    repeat (150) begin
      mem_valid  = ($urandom_range(0, 3) == 0);
      alu_valid  = ($urandom_range(0, 1) == 0);
      mem_rd     = 5'($urandom_range(0, 31));
      alu_rd     = 5'($urandom_range(0, 31));
      mem_data   = $urandom;
      alu_data   = $urandom;
      write_done = ($urandom_range(0, 2) != 0);
      step();
    end
    mem_valid = 0; alu_valid = 0; write_done = 1;
    repeat (6) step();
    chk("rand_drain_wa", write_activate, 0);

    // reset with two entries in flight
    write_done = 0;
    alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h9999_0009;
    step();
    alu_rd = 5'd10; alu_data = 32'h1010_0010;
    step();
    alu_valid = 0;
    chk("t6_wa_before", write_activate, 1);
    chk("t6_pmask_before", pending_mask, 32'h0000_0600);
    #2 rst = 1'b0;
    #1;
    chk("t6_wa_rst", write_activate, 0);
    chk("t6_pmask_rst", pending_mask, 0);
    chk("t6_retired_rst", retired_count, 0);
    exp_q.delete();
    model_ret = '0;
    write_done = 1;
    repeat (2) step();
    rst = 1'b1;
    repeat (4) step();
    chk("t6_wa_after", write_activate, 0);
    chk("t6_retired_after", retired_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Writeback stage sitting directly upstream of the register file.
- Collects completed results from the ALU and the load/memory unit through valid/ready handshakes and buffers them in an in-order queue.
- Drives the register file write port (write_register / write_data / write_activate) and retires each entry on write_done.
- Exports a pending-destination mask so decode can stall on read-after-write hazards.

Parameters:
- DATA_WIDTH, 32, width of result data and register file write data.
- REG_ADDR_WIDTH, 5, width of a register index; the register file has 2**REG_ADDR_WIDTH registers.
- QUEUE_DEPTH, 4, number of buffered writeback entries; must be a power of two and at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- alu_valid  input  1  ALU result available.
- alu_ready  output  1  ALU result accepted at this edge if alu_valid is also high.
- alu_rd  input  REG_ADDR_WIDTH  ALU destination register.
- alu_data  input  DATA_WIDTH  ALU result.
- mem_valid  input  1  load result available.
- mem_ready  output  1  load result accepted at this edge if mem_valid is also high.
- mem_rd  input  REG_ADDR_WIDTH  load destination register.
- mem_data  input  DATA_WIDTH  load result.
- write_register  output  REG_ADDR_WIDTH  register file write index.
- write_data  output  DATA_WIDTH  register file write data.
- write_activate  output  1  register file write request.
- write_done  input  1  register file commit acknowledge.
- pending_mask  output  2**REG_ADDR_WIDTH  bit i set when a queued entry targets register i.
- retired_count  output  32  count of committed register writes.

Behaviour:
- Reset (rst low, asynchronous):
  - Queue emptied.
  - write_activate=0, write_register=0, write_data=0.
  - pending_mask=0, retired_count=0.
  - Any in-flight write is aborted and its entry is lost.
  - Outputs take these values immediately, without waiting for a clock edge.
- Ready signals:
  - mem_ready = !full.
  - alu_ready = !full && !mem_valid. Memory has fixed priority over the ALU.
- Enqueue:
  - At most one enqueue per cycle, on a rising edge with valid && ready for a source.
  - An entry holds {rd, data}.
  - A full queue accepts nothing; there is no pass-through at full.
- Writes to register 0:
  - The handshake completes normally (ready obeys the rules above).
  - The entry is discarded: never stored, never issued.
  - retired_count and pending_mask are unaffected.
- Write port:
  - write_activate = !empty.
  - write_register and write_data come from the queue head; both are 0 when the queue is empty.
  - All three are driven from registered state only, with no combinational path from the source inputs.
  - An entry enqueued at edge N is presented from edge N onward if the queue was empty, so a write can commit at the earliest at edge N+1.
- Commit:
  - write_done high at a rising edge while write_activate is high commits the head: it is popped and retired_count increments.
  - retired_count wraps from 0xFFFF_FFFF to 0.
  - The next entry is presented after that edge, so the peak rate is one commit per cycle.
  - write_done while write_activate is low is ignored.
  - The head is held stable while write_done stays low.
- Simultaneous enqueue and commit in one cycle: occupancy is unchanged and order is preserved. This requires the queue to be non-full before the edge.
- Ordering: strictly first-in first-out. A later write to the same register commits after an earlier one.
- pending_mask:
  - OR over the valid queue entries of one-hot(rd); bit 0 is always 0.
  - Reflects post-edge queue state, so it is valid in the same cycle that write_activate reflects that state.
- The queue pointers wrap modulo QUEUE_DEPTH. Full and empty are distinguished with an extra pointer bit.

Decomposition:
- Shared package cpu_pkg holds:
  - word_t (DATA_WIDTH bits) and reg_addr_t (REG_ADDR_WIDTH bits).
  - wb_entry_t struct {reg_addr_t rd; word_t data}.
  - ZERO_REG constant = 0.
- One sub-module, writeback_fifo:
  - Generic synchronous FIFO of wb_entry_t, depth QUEUE_DEPTH.
  - Push/pop/full/empty plus an entry-valid vector, exposed so the parent can build pending_mask.
- The parent writeback_unit holds the arbitration, the register-0 filter, the commit logic and the counter.

Test Plan:
1. Assert rst low mid-cycle -> write_activate=0, pending_mask=0, retired_count=0 immediately; after release with both valids low -> alu_ready=1, mem_ready=1.
2. ALU rd=1 data=0xDEAD_BEEF for one edge, write_done held high -> next cycle write_activate=1, write_register=1, write_data=0xDEAD_BEEF, pending_mask=0x0000_0002; following edge -> write_activate=0, pending_mask=0, retired_count=1.
3. alu_valid and mem_valid high together (ALU rd=2 data=0x1111_1111, load rd=3 data=0x2222_2222) -> alu_ready=0 that cycle and the load is accepted; the ALU entry is accepted the next edge; commits occur in order rd=3 then rd=2.
4. ALU rd=0 data=0xFFFF_FFFF -> handshake completes, write_activate stays 0, retired_count unchanged, pending_mask=0.
5. write_done held low, loads to rd=4,5,6,7 -> after the 4th, mem_ready=0, alu_ready=0, pending_mask=0x0000_00F0; a 5th load stays unaccepted; then hold write_done high -> four commits on consecutive edges in order 4,5,6,7, retired_count=4, ready returns after the first commit.
6. Two entries queued, write_done low, then rst pulsed low -> write_activate drops immediately, the queue is empty after release, and no commit of either entry is ever observed.
